// File: rtl/seq_mag_comparator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_mag_comparator                                            |
// | Purpose  : Multi-cycle G/L/E magnitude compare, DIGIT bits per clock,    |
// |            MSB chunk first; signed mode via offset-binary conversion.    |
// | Option   : SEQ_MAG_COMPARATOR_EARLY_EXIT_EN (stop on first differing     |
// |            chunk; default build is constant-time).                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             L,
    output logic             E
);

    localparam int c_NCHUNK = WIDTH / DIGIT;
    localparam int c_IDXW   = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam int c_NSLOT  = 1 << c_IDXW;
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_NCHUNK - 1);
    localparam logic [c_IDXW-1:0] c_IDX_ONE  = c_IDXW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CMP  = 1'b1
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_a_q, w_a_d;
    logic [WIDTH-1:0]   r_b_q, w_b_d;
    logic [c_IDXW-1:0]  r_idx_q, w_idx_d;
    logic               r_gt_q, w_gt_d;
    logic               r_lt_q, w_lt_d;
    logic               r_busy_q, w_busy_d;
    logic               r_done_q, w_done_d;
    logic               r_g_q, w_g_d;
    logic               r_l_q, w_l_d;
    logic               r_e_q, w_e_d;

    logic [WIDTH-1:0]   w_flip;
    logic [DIGIT-1:0]   w_a_chunk [c_NSLOT];
    logic [DIGIT-1:0]   w_b_chunk [c_NSLOT];
    logic [DIGIT-1:0]   w_ca, w_cb;
    logic               w_dec_gt, w_dec_lt, w_last;

    // Chunk table padded to a power of two so the index width always matches.
    generate
        for (genvar i = 0; i < c_NSLOT; i++) begin : g_chunk
            if (i < c_NCHUNK) begin : g_used
                assign w_a_chunk[i] = r_a_q[i*DIGIT +: DIGIT];
                assign w_b_chunk[i] = r_b_q[i*DIGIT +: DIGIT];
            end else begin : g_pad
                assign w_a_chunk[i] = '0;
                assign w_b_chunk[i] = '0;
            end
        end
    endgenerate

    assign w_ca = w_a_chunk[r_idx_q];
    assign w_cb = w_b_chunk[r_idx_q];

    // A decision made on a more significant chunk is sticky.
    assign w_dec_gt = r_gt_q | (~r_lt_q & (w_ca > w_cb));
    assign w_dec_lt = r_lt_q | (~r_gt_q & (w_ca < w_cb));

`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
    assign w_last = (r_idx_q == '0) || (w_ca != w_cb);
`else
    assign w_last = (r_idx_q == '0);
`endif

    always_comb begin
        w_flip            = '0;
        w_flip[WIDTH-1]   = is_signed;
        w_state_d         = r_state_q;
        w_a_d             = r_a_q;
        w_b_d             = r_b_q;
        w_idx_d           = r_idx_q;
        w_gt_d            = r_gt_q;
        w_lt_d            = r_lt_q;
        w_busy_d          = r_busy_q;
        w_done_d          = 1'b0;
        w_g_d             = r_g_q;
        w_l_d             = r_l_q;
        w_e_d             = r_e_q;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_a_d     = a ^ w_flip;
                    w_b_d     = b ^ w_flip;
                    w_gt_d    = 1'b0;
                    w_lt_d    = 1'b0;
                    w_g_d     = 1'b0;
                    w_l_d     = 1'b0;
                    w_e_d     = 1'b0;
                    w_busy_d  = 1'b1;
                    w_idx_d   = c_LAST_IDX;
                    w_state_d = S_CMP;
                end
            end
            S_CMP: begin
                w_gt_d = w_dec_gt;
                w_lt_d = w_dec_lt;
                if (w_last) begin
                    w_g_d     = w_dec_gt;
                    w_l_d     = w_dec_lt;
                    w_e_d     = ~(w_dec_gt | w_dec_lt);
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_idx_d   = c_LAST_IDX;
                    w_state_d = S_IDLE;
                end else begin
                    w_idx_d   = r_idx_q - c_IDX_ONE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_idx_q   <= c_LAST_IDX;
            r_gt_q    <= 1'b0;
            r_lt_q    <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_g_q     <= 1'b0;
            r_l_q     <= 1'b0;
            r_e_q     <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_idx_q   <= w_idx_d;
            r_gt_q    <= w_gt_d;
            r_lt_q    <= w_lt_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_g_q     <= w_g_d;
            r_l_q     <= w_l_d;
            r_e_q     <= w_e_d;
        end
    end

    assign busy = r_busy_q;
    assign done = r_done_q;
    assign G    = r_g_q;
    assign L    = r_l_q;
    assign E    = r_e_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mag_comparator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_mag_comparator                                         |
// | Purpose  : Scoreboard bench for seq_mag_comparator (directed + random).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_mag_comparator;

    localparam int WIDTH  = 16;
    localparam int DIGIT  = 4;
    localparam int NCHUNK = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             is_signed = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, G, L, E;

    seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .is_signed(is_signed), .busy(busy), .done(done), .G(G), .L(L), .E(E)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] gle;
        int         lat;
        int         issue;
        string      name;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] last_gle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer compare, {G,L,E}.
    function automatic logic [2:0] model_gle(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic s);
        int vx, vy;
        vx = s ? int'($signed(x)) : int'(x);
        vy = s ? int'($signed(y)) : int'(y);
        if (vx > vy)      return 3'b100;
        else if (vx < vy) return 3'b010;
        else              return 3'b001;
    endfunction

    // Cycles from accepted start to done.
    function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SEQ_MAG_COMPARATOR_EARLY_EXIT_EN
        for (int j = 1; j <= NCHUNK; j++) begin
            if (((x >> ((NCHUNK - j) * DIGIT)) % (1 << DIGIT)) !=
                ((y >> ((NCHUNK - j) * DIGIT)) % (1 << DIGIT)))
                return j;
        end
        return NCHUNK;
`else
        if (x == y) return NCHUNK;
        return NCHUNK;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_gle"}, {29'd0, G, L, E}, {29'd0, e.gle});
                chk({e.name, "_lat"}, cyc - e.issue, e.lat);
                chk({e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            end
        end
    end

    // Caller must be at a negedge (or in the done cycle) when calling.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                         input string name);
        exp_t e;
        a = x; b = y; is_signed = s; start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        e.gle    = model_gle(x, y, s);
        e.lat    = model_lat(x, y);
        e.issue  = cyc;
        e.name   = name;
        last_gle = e.gle;
        sb.push_back(e);
    endtask

    // Returns at the negedge of the done cycle; inputs optionally scrambled meanwhile.
    task automatic wait_done(input bit noise);
        int n;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (done) break;
            if (noise) begin
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
                is_signed = 1'($urandom);
            end
        end
        if (n == 64) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                       input string name);
        @(negedge clk);
        issue(x, y, s, name);
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_gle",  {29'd0, G, L, E}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(16'h1234, 16'h1234, 1'b0, "eq_1234");
        run(16'h8000, 16'h7FFF, 1'b0, "msb_unsigned");
        run(16'h8000, 16'h7FFF, 1'b1, "msb_signed");
        run(16'h12F0, 16'h12E0, 1'b0, "chunk1_gt");

        // Start during busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        issue(16'h0001, 16'h0002, 1'b0, "first_lt");
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignored_start_busy", {31'd0, busy}, 32'd1);
        wait_done(1'b0);
        issue(16'hFFFF, 16'h0000, 1'b0, "b2b_gt");
        chk("no_bubble_busy", {31'd0, busy}, 32'd1);
        wait_done(1'b0);

        // Asynchronous reset mid-compare.
        @(negedge clk);
        issue(16'h1231, 16'h1232, 1'b0, "aborted");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_gle",  {29'd0, G, L, E}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(16'h0003, 16'h0003, 1'b0, "post_reset_eq");

        run(16'hFFFF, 16'h0001, 1'b1, "signed_m1_lt_1");
        run(16'h0000, 16'hFFFF, 1'b1, "signed_0_gt_m1");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_gle", {29'd0, G, L, E}, {29'd0, last_gle});
        end
        run(16'h0000, 16'h0000, 1'b0, "all_zero");
        run(16'hFFFF, 16'hFFFF, 1'b1, "all_one");

        for (int i = 0; i < 80; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = WIDTH'($urandom);
                1:       rb = ra;
                2:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: rb = ra ^ (WIDTH'($urandom_range(1, 15)) << (DIGIT * $urandom_range(0, NCHUNK - 1)));
            endcase
            rs = 1'($urandom);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            issue(ra, rb, rs, "rand");
            wait_done(1'b1);
        end

        repeat (8) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
